key_event_spi_tx: RTL and testbench

KEY_EVENT_SPI_TX -- requirements
Module: key_event_spi_tx

---
 rtl/key_pkg.sv | 27 ++
 rtl/key_event_fifo.sv | 54 +++++
 rtl/key_event_spi_tx.sv | 160 ++++++++++++++++
 tb/tb_key_event_spi_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants, header layout and FSM encoding for the key event SPI transmitter.
package key_pkg;

    localparam int EVT_WIDTH  = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int HDR_BITS   = 8;
    localparam int FRAME_BITS = HDR_BITS + EVT_WIDTH;

    localparam int HDR_NONEMPTY_BIT = 7;
    localparam int HDR_OVERFLOW_BIT = 6;
    localparam int HDR_COUNT_MSB    = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } tx_state_t;

    // The header count field is four bits wide, so deeper queues report 15.
    function automatic logic [3:0] sat_count(input int unsigned c);
        if (c > 15) begin
            return 4'd15;
        end
        return c[3:0];
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous event queue; pointers carry one extra wrap bit so full and empty are distinct.
module key_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // A push into a full queue is legal when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/key_event_spi_tx.sv
// Queues key events and serves them to an SPI host as {header, event} frames, popping
// only after the host has clocked out a complete frame.
module key_event_spi_tx
    import key_pkg::*;
#(
    parameter int EVT_WIDTH  = key_pkg::EVT_WIDTH,
    parameter int FIFO_DEPTH = key_pkg::FIFO_DEPTH,
    parameter int FRAME_BITS = key_pkg::FRAME_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          evt_valid,
    input  logic [EVT_WIDTH-1:0]          evt_code,
    input  logic                          spi_sel,
    input  logic                          spi_sck,
    output logic                          spi_sdo,
    output logic                          irq,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output tx_state_t                     fsm_state
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    logic                  sel_s1, sel_s2, sel_prev;
    logic                  sck_s1, sck_s2, sck_prev;
    logic [1:0]            warm;
    logic                  armed;
    logic                  sel_fall, sel_rise, sck_rise, sck_fall;

    tx_state_t             state;
    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      rise_cnt;
    logic                  snap_nonempty;
    logic                  snap_overflow;

    logic                  fifo_full, fifo_empty;
    logic [EVT_WIDTH-1:0]  fifo_head;
    logic                  pop;
    logic                  ovf_set, ovf_clr;
    logic [HDR_BITS-1:0]   header;
    logic [FRAME_BITS-1:0] frame_next;

    key_event_fifo #(
        .WIDTH (EVT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt_valid),
        .pop   (pop),
        .wdata (evt_code),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A frame may only start once a high chip select has been seen through a fully
    // refilled synchronizer, so a select held low across reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_s1   <= 1'b1;
            sel_s2   <= 1'b1;
            sel_prev <= 1'b1;
            sck_s1   <= 1'b0;
            sck_s2   <= 1'b0;
            sck_prev <= 1'b0;
            warm     <= 2'b00;
            armed    <= 1'b0;
        end else begin
            sel_s1   <= spi_sel;
            sel_s2   <= sel_s1;
            sel_prev <= sel_s2;
            sck_s1   <= spi_sck;
            sck_s2   <= sck_s1;
            sck_prev <= sck_s2;
            warm     <= {warm[0], 1'b1};
            if (warm[1] && sel_s2) begin
                armed <= 1'b1;
            end
        end
    end

    assign sel_fall = armed & sel_prev & ~sel_s2;
    assign sel_rise = ~sel_prev & sel_s2;
    assign sck_rise = sck_s2 & ~sck_prev;
    assign sck_fall = ~sck_s2 & sck_prev;

    assign header = {~fifo_empty, overflow, 2'b00, sat_count(32'(fifo_count))};
    assign frame_next = {header, (fifo_empty ? {EVT_WIDTH{1'b0}} : fifo_head)};

    // Zeros shift in behind the frame, so extra host clocks read back 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            rise_cnt      <= '0;
            snap_nonempty <= 1'b0;
            snap_overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    shreg <= '0;
                    if (sel_fall) begin
                        state         <= ST_SHIFT;
                        shreg         <= frame_next;
                        rise_cnt      <= '0;
                        snap_nonempty <= ~fifo_empty;
                        snap_overflow <= overflow;
                    end
                end
                ST_SHIFT: begin
                    if (sel_rise) begin
                        shreg <= '0;
                        if (rise_cnt == CNT_W'(FRAME_BITS)) begin
                            state <= ST_COMMIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        if (sck_rise && (rise_cnt != CNT_W'(FRAME_BITS))) begin
                            rise_cnt <= rise_cnt + 1'b1;
                        end
                        if (sck_fall) begin
                            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
                ST_COMMIT: begin
                    shreg <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    shreg <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pop     = (state == ST_COMMIT) & snap_nonempty;
    assign ovf_clr = (state == ST_COMMIT) & snap_overflow;
    assign ovf_set = evt_valid & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    assign spi_sdo   = shreg[FRAME_BITS-1];
    assign irq       = ~fifo_empty;
    assign fsm_state = state;

endmodule

// File: tb/tb_key_event_spi_tx.sv
// Bench for key_event_spi_tx: directed scenarios plus randomized frames against a queue model.
module tb_key_event_spi_tx;
    import key_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       evt_valid = 1'b0;
    logic [7:0] evt_code = 8'h00;
    logic       spi_sel = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_sdo;
    logic       irq;
    logic       overflow;
    logic [3:0] fifo_count;
    tx_state_t  fsm_state;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    bit         movf = 1'b0;

    always #5 clk = ~clk;

    key_event_spi_tx dut (
        .clk        (clk),
        .rst        (rst),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .spi_sel    (spi_sel),
        .spi_sck    (spi_sck),
        .spi_sdo    (spi_sdo),
        .irq        (irq),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .fsm_state  (fsm_state)
    );

    function automatic logic [15:0] model_frame();
        int         n;
        logic [7:0] hdr;
        logic [7:0] d;
        n   = mq.size();
        hdr = {(n > 0), movf, 2'b00, 4'((n > 15) ? 15 : n)};
        d   = (n > 0) ? mq[0] : 8'h00;
        return {hdr, d};
    endfunction

    task automatic model_push(input logic [7:0] c);
        if (mq.size() < 8) mq.push_back(c);
        else movf = 1'b1;
    endtask

    task automatic model_commit(input bit ne, input bit ov, input bit push, input logic [7:0] c);
        bit full_before;
        full_before = (mq.size() == 8);
        if (ov) movf = 1'b0;
        if (ne) void'(mq.pop_front());
        if (push) begin
            if (full_before && !ne) movf = 1'b1;
            else mq.push_back(c);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spi_sel = 1'b1;
        spi_sck = 1'b0;
        evt_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        movf = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic push_evt(input logic [7:0] c);
        evt_valid = 1'b1;
        evt_code  = c;
        @(negedge clk);
        evt_valid = 1'b0;
        model_push(c);
    endtask

    // Host side of one transaction: bits are sampled just before each sck rise (mode 0).
    task automatic do_frame(input int n_edges, input bit mid_push, input logic [7:0] mid_code,
                            input bit commit_push, input logic [7:0] commit_code,
                            output logic [15:0] got, output logic [15:0] exp_bits,
                            output int extra_ones, output tx_state_t commit_state);
        bit   snap_ne;
        bit   snap_ov;
        logic b;
        got          = '0;
        extra_ones   = 0;
        commit_state = ST_IDLE;
        exp_bits     = model_frame();
        snap_ne      = (mq.size() > 0);
        snap_ov      = movf;
        spi_sel = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < n_edges; i++) begin
            b = spi_sdo;
            if (i < 16) got = {got[14:0], b};
            else if (b === 1'b1) extra_ones++;
            spi_sck = 1'b1;
            repeat (5) @(negedge clk);
            spi_sck = 1'b0;
            repeat (5) @(negedge clk);
            if (mid_push && i == 3) push_evt(mid_code);
        end
        spi_sel = 1'b1;
        if (commit_push) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            evt_valid    = 1'b1;
            evt_code     = commit_code;
            commit_state = fsm_state;
            @(negedge clk);
            evt_valid = 1'b0;
        end
        repeat (6) @(negedge clk);
        if (n_edges >= 16) model_commit(snap_ne, snap_ov, commit_push, commit_code);
        else if (commit_push) model_push(commit_code);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_count !== 4'd0 || irq !== 1'b0 || overflow !== 1'b0 || spi_sdo !== 1'b0 || fsm_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset: count=%0d irq=%b ovf=%b sdo=%b state=%0d, required 0/0/0/0/IDLE",
                     fifo_count, irq, overflow, spi_sdo, fsm_state);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [15:0] got, expb;
        int          extra;
        tx_state_t   cs;
        push_evt(8'h3A);
        @(negedge clk);
        checks++;
        if (fifo_count !== 4'd1 || irq !== 1'b1) begin
            failures++;
            $display("FAIL single_push: count=%0d irq=%b, required 1/1", fifo_count, irq);
        end
        do_frame(16, 0, 8'h00, 0, 8'h00, got, expb, extra, cs);
        checks++;
        if (got !== 16'h813A) begin
            failures++;
            $display("FAIL single_frame: got %h, required 813a", got);
        end
        checks++;
        if (fifo_count !== 4'd0 || irq !== 1'b0 || spi_sdo !== 1'b0) begin
            failures++;
            $display("FAIL single_after: count=%0d irq=%b sdo=%b, required 0/0/0", fifo_count, irq, spi_sdo);
        end
    endtask

    task automatic test_empty();
        logic [15:0] got, expb;
        int          extra;
        tx_state_t   cs;
        do_frame(16, 0, 8'h00, 0, 8'h00, got, expb, extra, cs);
        checks++;
        if (got !== 16'h0000 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL empty_frame: got %h count=%0d ovf=%b, required 0000/0/0", got, fifo_count, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] got, expb;
        int          extra;
        tx_state_t   cs;
        for (int i = 1; i <= 9; i++) push_evt(8'(i));
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 4'd8) begin
            failures++;
            $display("FAIL overflow_set: ovf=%b count=%0d, required 1/8", overflow, fifo_count);
        end
        do_frame(16, 0, 8'h00, 0, 8'h00, got, expb, extra, cs);
        checks++;
        if (got !== 16'hC801) begin
            failures++;
            $display("FAIL overflow_frame: got %h, required c801", got);
        end
        checks++;
        if (overflow !== 1'b0 || fifo_count !== 4'd7) begin
            failures++;
            $display("FAIL overflow_clear: ovf=%b count=%0d, required 0/7", overflow, fifo_count);
        end
        do_reset();
    endtask

    task automatic test_abort();
        logic [15:0] got, expb;
        int          extra;
        tx_state_t   cs;
        push_evt(8'h55);
        do_frame(7, 0, 8'h00, 0, 8'h00, got, expb, extra, cs);
        checks++;
        if (fifo_count !== 4'd1 || irq !== 1'b1 || fsm_state !== ST_IDLE) begin
            failures++;
            $display("FAIL abort_nopop: count=%0d irq=%b state=%0d, required 1/1/IDLE", fifo_count, irq, fsm_state);
        end
        do_frame(16, 0, 8'h00, 0, 8'h00, got, expb, extra, cs);
        checks++;
        if (got !== 16'h8155) begin
            failures++;
            $display("FAIL abort_retry: got %h, required 8155", got);
        end
    endtask

    task automatic test_commit_push();
        logic [15:0] got, expb;
        int          extra;
        tx_state_t   cs;
        logic [7:0]  first;
        do_reset();
        first = 8'($urandom_range(0, 255));
        push_evt(first);
        for (int i = 1; i < 8; i++) push_evt(8'($urandom_range(0, 255)));
        do_frame(16, 0, 8'h00, 1, 8'h77, got, expb, extra, cs);
        checks++;
        if (got !== {8'h88, first} || cs !== ST_COMMIT) begin
            failures++;
            $display("FAIL commit_push_frame: got %h state=%0d, required %h/COMMIT", got, cs, {8'h88, first});
        end
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL commit_push_count: count=%0d ovf=%b, required 8/0", fifo_count, overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            do_frame(16, 0, 8'h00, 0, 8'h00, got, expb, extra, cs);
            checks++;
            if (got !== expb) begin
                failures++;
                $display("FAIL commit_push_drain%0d: got %h, required %h", i, got, expb);
            end
            if (i == 8) begin
                checks++;
                if (got[7:0] !== 8'h77) begin
                    failures++;
                    $display("FAIL commit_push_eighth: got %h, required 77", got[7:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got, expb;
        int          extra;
        tx_state_t   cs;
        do_reset();
        push_evt(8'h11);
        push_evt(8'h22);
        push_evt(8'h33);
        spi_sel = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            spi_sck = 1'b1;
            repeat (5) @(negedge clk);
            spi_sck = 1'b0;
            repeat (5) @(negedge clk);
        end
        checks++;
        if (fsm_state !== ST_SHIFT) begin
            failures++;
            $display("FAIL reset_mid_inshift: state=%0d, required SHIFT", fsm_state);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_count !== 4'd0 || spi_sdo !== 1'b0 || fsm_state !== ST_IDLE || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: count=%0d sdo=%b state=%0d irq=%b, required 0/0/IDLE/0",
                     fifo_count, spi_sdo, fsm_state, irq);
        end
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        movf = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (fsm_state !== ST_IDLE || spi_sdo !== 1'b0) begin
            failures++;
            $display("FAIL reset_sel_low: state=%0d sdo=%b, required IDLE/0", fsm_state, spi_sdo);
        end
        spi_sel = 1'b1;
        repeat (6) @(negedge clk);
        push_evt(8'hA5);
        do_frame(16, 0, 8'h00, 0, 8'h00, got, expb, extra, cs);
        checks++;
        if (got !== 16'h81A5 || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_fresh_frame: got %h count=%0d, required 81a5/0", got, fifo_count);
        end
    endtask

    task automatic test_random();
        logic [15:0] got, expb;
        int          extra;
        tx_state_t   cs;
        int          n_edges;
        bit          mid;
        for (int it = 0; it < 25; it++) begin
            for (int p = 0; p < int'($urandom_range(0, 3)); p++) push_evt(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 9) < 2) n_edges = int'($urandom_range(1, 15));
            else n_edges = 16 + int'($urandom_range(0, 2));
            mid = 1'($urandom_range(0, 1));
            do_frame(n_edges, mid, 8'($urandom_range(0, 255)), 0, 8'h00, got, expb, extra, cs);
            if (n_edges >= 16) begin
                checks++;
                if (got !== expb || extra != 0) begin
                    failures++;
                    $display("FAIL random_frame%0d: got %h extra_ones=%0d, required %h/0", it, got, extra, expb);
                end
            end
            checks++;
            if (fifo_count !== 4'(mq.size()) || overflow !== movf || irq !== (mq.size() > 0)) begin
                failures++;
                $display("FAIL random_state%0d: count=%0d ovf=%b irq=%b, required %0d/%b/%b",
                         it, fifo_count, overflow, irq, mq.size(), movf, (mq.size() > 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty();
        test_overflow();
        test_abort();
        test_commit_push();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
